// File: rtl/trap_csr_if.sv
// Bundle between the instruction decoder / PC logic and the machine-mode
// trap and CSR unit. The master side is the decoder, the slave side the
// trap unit.
interface trap_csr_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic [7:0]  scause;
  logic        mret;
  logic        irq;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        kill;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mie_global;

  modport master (
    output instr_valid, pc, scause, mret, irq, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, kill, redirect, redirect_pc, mie_global
  );

  modport slave (
    input  instr_valid, pc, scause, mret, irq, csr_op, csr_addr, csr_wdata,
    output csr_rdata, kill, redirect, redirect_pc, mie_global
  );
endinterface

// File: rtl/trap_csr.sv
// Machine-mode trap and CSR unit. Detects exceptions, mret and external
// interrupts on the current instruction, kills its side effects, and one
// cycle later redirects the PC to mtvec or mepc. Owns mstatus, mie, mip,
// mtvec, mepc, mcause and the 64-bit mcycle counter.
module trap_csr #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [7:0]  SC_NOP      = 8'h00,
  parameter logic [7:0]  SC_ECALL    = 8'h0B,
  parameter logic [7:0]  SC_ILLEGAL  = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  trap_csr_if.slave  bus
);

  typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  state_t      state_q, state_d;
  logic        mie_bit, mpie_bit, meie_bit;
  logic [31:0] mtvec, mepc, mcause;
  logic [63:0] mcycle, mcycle_d;

  logic [31:0] csr_old, csr_new;
  logic        active, exc_ev, ret_ev, irq_ev, csr_we;
  logic        kill, redirect;
  logic [31:0] redirect_pc;

  // Read-modify-write rule shared by every writable CSR.
  function automatic logic [31:0] csr_update(input logic [1:0] op,
                                             input logic [31:0] old,
                                             input logic [31:0] wdata);
    case (op)
      2'b01:   csr_update = wdata;
      2'b10:   csr_update = old | wdata;
      2'b11:   csr_update = old & ~wdata;
      default: csr_update = old;
    endcase
  endfunction

  // Combinational CSR read mux; always returns the pre-write value.
  always_comb begin
    csr_old = '0;
    case (bus.csr_addr)
      A_MSTATUS: csr_old = {19'd0, 2'b11, 3'd0, mpie_bit, 3'd0, mie_bit, 3'd0};
      A_MIE:     csr_old = {20'd0, meie_bit, 11'd0};
      A_MTVEC:   csr_old = mtvec;
      A_MIP:     csr_old = {20'd0, bus.irq, 11'd0};
      A_MEPC:    csr_old = mepc;
      A_MCAUSE:  csr_old = mcause;
      A_MCYCLE:  csr_old = mcycle[31:0];
      A_MCYCLEH: csr_old = mcycle[63:32];
      default:   csr_old = '0;
    endcase
  end

  assign csr_new = csr_update(bus.csr_op, csr_old, bus.csr_wdata);

  // Event priority: exception, then mret, then interrupt; a CSR write only
  // commits when none of them fires.
  assign active = bus.instr_valid & (state_q == RUN);
  assign exc_ev = active & (bus.scause != SC_NOP);
  assign ret_ev = active & ~exc_ev & bus.mret;
  assign irq_ev = active & ~exc_ev & ~bus.mret & bus.irq & mie_bit & meie_bit;
  assign csr_we = active & ~exc_ev & ~bus.mret & ~irq_ev & (bus.csr_op != 2'b00);

  // mcycle next value: a write to one half replaces that half, the other holds.
  always_comb begin
    mcycle_d = mcycle + 64'd1;
    if (csr_we && bus.csr_addr == A_MCYCLE) begin
      mcycle_d = {mcycle[63:32], csr_new};
    end else if (csr_we && bus.csr_addr == A_MCYCLEH) begin
      mcycle_d = {csr_new, mcycle[31:0]};
    end
  end

  // CSR state: trap entry, mret, software writes and the cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit  <= 1'b0;
      mpie_bit <= 1'b0;
      meie_bit <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
    end else begin
      mcycle <= mcycle_d;
      if (exc_ev || irq_ev) begin
        mepc     <= bus.pc & 32'hFFFF_FFFC;
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
        if (irq_ev)
          mcause <= CAUSE_MEI;
        else if (bus.scause == SC_ECALL)
          mcause <= {24'd0, SC_ECALL};
        else
          mcause <= {24'd0, SC_ILLEGAL};
      end else if (ret_ev) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end else if (csr_we) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            mie_bit  <= csr_new[3];
            mpie_bit <= csr_new[7];
          end
          A_MIE:   meie_bit <= csr_new[11];
          A_MTVEC: mtvec    <= csr_new & 32'hFFFF_FFFC;
          A_MEPC:  mepc     <= csr_new & 32'hFFFF_FFFC;
          A_MCAUSE: mcause  <= csr_new;
          default: ;
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state and kill/redirect outputs.
  always_comb begin
    state_d     = state_q;
    kill        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      RUN: begin
        kill = exc_ev | irq_ev;
        if (exc_ev || irq_ev) state_d = TRAP;
        else if (ret_ev)      state_d = RET;
      end
      TRAP: begin
        kill        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = mtvec;
        state_d     = RUN;
      end
      RET: begin
        kill        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = mepc;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.csr_rdata   = csr_old;
  assign bus.kill        = kill;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.mie_global  = mie_bit;

endmodule
